// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer for the 8x8 matmul block: writes streamed A/B rows into the
// block's RAMs, runs the multiply, then streams C rows back through a credit-limited buffer.
module matmul_host_sequencer #(
  parameter int DWIDTH       = 16,
  parameter int MAT_SIZE     = 8,
  parameter int AWIDTH       = 7,
  parameter int WR_LAT       = 2,
  parameter int RD_LAT       = 3,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MAT_SIZE*DWIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MAT_SIZE*DWIDTH-1:0] out_data,
  output logic                       busy,
  output logic                       error,
  output logic                       enable_writing_to_mem,
  output logic                       enable_reading_from_mem,
  output logic [AWIDTH-1:0]          addr_pi,
  output logic [MAT_SIZE*DWIDTH-1:0] data_pi,
  output logic                       we_a,
  output logic                       we_b,
  output logic                       we_c,
  output logic                       start_mat_mul,
  input  logic                       done_mat_mul,
  input  logic [MAT_SIZE*DWIDTH-1:0] data_from_out_mat
);
  localparam int ROW_W = MAT_SIZE*DWIDTH;
  localparam int CW    = $clog2(MAT_SIZE+1);
  localparam int TW    = $clog2(DONE_TIMEOUT);
  localparam int DW    = $clog2(WR_LAT+2);
  localparam int BUF_D = RD_LAT+1;
  localparam int BW    = $clog2(BUF_D+1);
  localparam int PW    = $clog2(BUF_D);

  localparam logic [CW-1:0] ROWS     = CW'(MAT_SIZE);
  localparam logic [CW-1:0] LAST_ROW = CW'(MAT_SIZE-1);
  localparam logic [TW-1:0] T_LAST   = TW'(DONE_TIMEOUT-1);
  localparam logic [DW-1:0] D_LAST   = DW'(WR_LAT);
  localparam logic [BW-1:0] CREDITS  = BW'(BUF_D);
  localparam logic [PW-1:0] P_LAST   = PW'(BUF_D-1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_DRAIN, S_COMPUTE, S_GAP, S_READ_C
  } state_t;

  state_t                       state;
  logic [CW-1:0]                row_cnt, issue_cnt, pop_cnt;
  logic [DW-1:0]                drain_cnt;
  logic [TW-1:0]                cmp_cnt;
  logic [AWIDTH-1:0]            addr_q;
  logic [WR_LAT-1:0][ROW_W-1:0] wr_data_pipe;
  logic [WR_LAT-1:0]            wr_a_pipe, wr_b_pipe;
  logic [RD_LAT:1]              vld_pipe;
  logic [BW-1:0]                credit, rcnt;
  logic [PW-1:0]                rd_ptr, wr_ptr;
  logic [ROW_W-1:0]             rbuf [BUF_D];
  logic                         accept, issue, push, pop;

  // Credit = rows in flight through the RAM read pipe plus rows buffered, so the
  // buffer can never overflow no matter how long out_ready stays low.
  assign accept    = in_valid & in_ready;
  assign issue     = (state == S_READ_C) && (issue_cnt < ROWS) && (credit < CREDITS);
  assign push      = vld_pipe[RD_LAT];
  assign pop       = out_valid & out_ready;
  assign out_valid = (rcnt != '0);
  assign out_data  = rbuf[rd_ptr];
  assign addr_pi   = accept ? AWIDTH'(row_cnt) : issue ? AWIDTH'(issue_cnt) : addr_q;
  assign data_pi   = wr_data_pipe[WR_LAT-1];
  assign we_a      = wr_a_pipe[WR_LAT-1];
  assign we_b      = wr_b_pipe[WR_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      wr_data_pipe <= '0;
      wr_a_pipe    <= '0;
      wr_b_pipe    <= '0;
      vld_pipe     <= '0;
      credit       <= '0;
      rcnt         <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      for (int i = 0; i < BUF_D; i++) rbuf[i] <= '0;
    end else begin
      addr_q          <= addr_pi;
      wr_data_pipe[0] <= accept ? in_data : '0;
      wr_a_pipe[0]    <= accept && (state == S_LOAD_A);
      wr_b_pipe[0]    <= accept && (state == S_LOAD_B);
      for (int i = 1; i < WR_LAT; i++) begin
        wr_data_pipe[i] <= wr_data_pipe[i-1];
        wr_a_pipe[i]    <= wr_a_pipe[i-1];
        wr_b_pipe[i]    <= wr_b_pipe[i-1];
      end
      vld_pipe[1] <= issue;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      credit <= credit + BW'(issue) - BW'(pop);
      rcnt   <= rcnt + BW'(push) - BW'(pop);
      if (push) begin
        rbuf[wr_ptr] <= data_from_out_mat;
        wr_ptr       <= (wr_ptr == P_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == P_LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= S_IDLE;
      row_cnt                 <= '0;
      issue_cnt               <= '0;
      pop_cnt                 <= '0;
      drain_cnt               <= '0;
      cmp_cnt                 <= '0;
      in_ready                <= 1'b0;
      busy                    <= 1'b0;
      error                   <= 1'b0;
      enable_writing_to_mem   <= 1'b0;
      enable_reading_from_mem <= 1'b0;
      start_mat_mul           <= 1'b0;
      we_c                    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (go) begin
          state                 <= S_LOAD_A;
          error                 <= 1'b0;
          busy                  <= 1'b1;
          in_ready              <= 1'b1;
          enable_writing_to_mem <= 1'b1;
          row_cnt               <= '0;
        end
        S_LOAD_A: if (accept) begin
          if (row_cnt == LAST_ROW) begin
            row_cnt <= '0;
            state   <= S_LOAD_B;
          end else row_cnt <= row_cnt + 1'b1;
        end
        S_LOAD_B: if (accept) begin
          if (row_cnt == LAST_ROW) begin
            row_cnt   <= '0;
            in_ready  <= 1'b0;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else row_cnt <= row_cnt + 1'b1;
        end
        // Let the last B writes leave the delay line before the multiply starts.
        S_DRAIN: begin
          if (drain_cnt == D_LAST) begin
            state                 <= S_COMPUTE;
            enable_writing_to_mem <= 1'b0;
            start_mat_mul         <= 1'b1;
            we_c                  <= 1'b1;
            cmp_cnt               <= '0;
          end else drain_cnt <= drain_cnt + 1'b1;
        end
        S_COMPUTE: begin
          if (done_mat_mul) begin
            state         <= S_GAP;
            start_mat_mul <= 1'b0;
            we_c          <= 1'b0;
          end else if (cmp_cnt == T_LAST) begin
            state         <= S_IDLE;
            error         <= 1'b1;
            busy          <= 1'b0;
            start_mat_mul <= 1'b0;
            we_c          <= 1'b0;
          end else cmp_cnt <= cmp_cnt + 1'b1;
        end
        S_GAP: begin
          state                   <= S_READ_C;
          enable_reading_from_mem <= 1'b1;
          issue_cnt               <= '0;
          pop_cnt                 <= '0;
        end
        S_READ_C: begin
          if (issue) issue_cnt <= issue_cnt + 1'b1;
          if (pop) begin
            if (pop_cnt == LAST_ROW) begin
              state                   <= S_IDLE;
              busy                    <= 1'b0;
              enable_reading_from_mem <= 1'b0;
            end else pop_cnt <= pop_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Bench for matmul_host_sequencer: models the multiply block's RAMs and latencies,
// checks write alignment, C readback against a golden product, and error/reset paths.
module tb_matmul_host_sequencer;
  localparam int DW = 16, MS = 8, AW = 7, WRL = 2, RDL = 3, TMO = 1024;
  localparam int RW = MS*DW;

  logic          clk = 1'b0, reset = 1'b1, go = 1'b0, in_valid = 1'b0;
  logic          out_ready = 1'b0, done_mat_mul = 1'b0;
  logic [RW-1:0] in_data = '0, data_from_out_mat = '0;
  logic          in_ready, out_valid, busy, error, enable_writing_to_mem, enable_reading_from_mem;
  logic          we_a, we_b, we_c, start_mat_mul;
  logic [AW-1:0] addr_pi;
  logic [RW-1:0] out_data, data_pi;

  matmul_host_sequencer #(.DWIDTH(DW), .MAT_SIZE(MS), .AWIDTH(AW), .WR_LAT(WRL),
                          .RD_LAT(RDL), .DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .go(go), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .error(error), .enable_writing_to_mem(enable_writing_to_mem),
    .enable_reading_from_mem(enable_reading_from_mem), .addr_pi(addr_pi), .data_pi(data_pi),
    .we_a(we_a), .we_b(we_b), .we_c(we_c), .start_mat_mul(start_mat_mul),
    .done_mat_mul(done_mat_mul), .data_from_out_mat(data_from_out_mat));

  always #5 clk = ~clk;

  int            n_tests = 0, n_fail = 0;
  logic [RW-1:0] a_exp[MS], b_exp[MS], c_exp[MS], ram_a[MS], ram_b[MS], ram_c[MS];
  logic [AW-1:0] addr_hist[8];
  int            wa_idx, wb_idx, out_idx, rd_issued;
  bit            prev_hold, out_seen, s_in_ready;
  logic [RW-1:0] prev_data;

  task automatic chk_r(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // C = A*B over DW-bit elements, element j of a row at bits [j*DW +: DW].
  task automatic matmul(input bit from_ram);
    logic [RW-1:0] a[MS], b[MS], c;
    for (int i = 0; i < MS; i++) begin
      a[i] = from_ram ? ram_a[i] : a_exp[i];
      b[i] = from_ram ? ram_b[i] : b_exp[i];
    end
    for (int i = 0; i < MS; i++) begin
      c = '0;
      for (int j = 0; j < MS; j++) begin
        int unsigned s = 0;
        for (int k = 0; k < MS; k++) begin
          logic [DW-1:0] x, y;
          x = a[i][k*DW +: DW];
          y = b[k][j*DW +: DW];
          s = s + 32'(x) * 32'(y);
        end
        c[j*DW +: DW] = s[DW-1:0];
      end
      if (from_ram) ram_c[i] = c; else c_exp[i] = c;
    end
  endtask

  task automatic set_identity();
    for (int i = 0; i < MS; i++)
      for (int j = 0; j < MS; j++) begin
        a_exp[i][j*DW +: DW] = (i == j) ? 16'd1 : 16'd0;
        b_exp[i][j*DW +: DW] = DW'(i*MS + j + 1);
      end
  endtask

  task automatic set_random();
    for (int i = 0; i < MS; i++)
      for (int j = 0; j < MS; j++) begin
        a_exp[i][j*DW +: DW] = DW'($urandom);
        b_exp[i][j*DW +: DW] = DW'($urandom);
      end
  endtask

  task automatic job_init();
    wa_idx = 0; wb_idx = 0; out_idx = 0; rd_issued = 0;
    prev_hold = 1'b0; out_seen = 1'b0;
  endtask

  // One clock: observe at the falling edge (RAM model + stream checks), then
  // return just after the rising edge with the RAM read data for the new cycle.
  task automatic step();
    int ad;
    @(negedge clk);
    s_in_ready = in_ready;
    ad = int'(addr_hist[WRL-1]) % MS;
    if (we_a) begin
      if (wa_idx < MS) begin
        chk_i("we_a_addr", int'(addr_hist[WRL-1]), wa_idx);
        chk_r("we_a_data", data_pi, a_exp[wa_idx]);
      end else chk_i("we_a_extra", wa_idx, MS - 1);
      ram_a[ad] = data_pi;
      wa_idx++;
    end
    if (we_b) begin
      if (wb_idx < MS) begin
        chk_i("we_b_addr", int'(addr_hist[WRL-1]), wb_idx);
        chk_r("we_b_data", data_pi, b_exp[wb_idx]);
      end else chk_i("we_b_extra", wb_idx, MS - 1);
      ram_b[ad] = data_pi;
      wb_idx++;
    end
    if (prev_hold) begin
      chk_b("out_valid_held", out_valid, 1'b1);
      chk_r("out_data_stable", out_data, prev_data);
    end
    if (out_valid) out_seen = 1'b1;
    if (out_valid && out_ready) begin
      if (out_idx < MS) chk_r("c_row", out_data, c_exp[out_idx]);
      else chk_i("c_row_extra", out_idx, MS - 1);
      out_idx++;
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    if (enable_reading_from_mem) begin
      if (int'(addr_pi) + 1 > rd_issued) rd_issued = int'(addr_pi) + 1;
      chk_b("in_ready_in_read", in_ready, 1'b0);
    end
    for (int i = 7; i > 0; i--) addr_hist[i] = addr_hist[i-1];
    addr_hist[0] = addr_pi;
    @(posedge clk);
    #1;
    data_from_out_mat = ram_c[int'(addr_hist[RDL-1]) % MS];
  endtask

  task automatic stream_rows(input int n, input int vprob);
    int idx = 0, cyc = 0;
    while (idx < n && cyc < 400) begin
      in_valid = (int'($urandom_range(99)) < vprob);
      in_data  = (idx < MS) ? a_exp[idx] : b_exp[idx - MS];
      step();
      cyc++;
      if (in_valid && s_in_ready) idx++;
    end
    in_valid = 1'b0;
    chk_i("rows_accepted", idx, n);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk_b({tag, "_in_ready"}, in_ready, 1'b0);
    chk_b({tag, "_out_valid"}, out_valid, 1'b0);
    chk_r({tag, "_out_data"}, out_data, '0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_error"}, error, 1'b0);
    chk_b({tag, "_en_wr"}, enable_writing_to_mem, 1'b0);
    chk_b({tag, "_en_rd"}, enable_reading_from_mem, 1'b0);
    chk_i({tag, "_addr"}, int'(addr_pi), 0);
    chk_r({tag, "_data_pi"}, data_pi, '0);
    chk_b({tag, "_we_a"}, we_a, 1'b0);
    chk_b({tag, "_we_b"}, we_b, 1'b0);
    chk_b({tag, "_we_c"}, we_c, 1'b0);
    chk_b({tag, "_start"}, start_mat_mul, 1'b0);
  endtask

  // rmode: 0 ready always, 1 ready random, 2 ready low for the first 20 READ_C cycles
  task automatic do_job(input int vprob, input int rmode, input bit never_done,
                        input int done_lat, input bit go_in_compute, input bit valid_in_read);
    int cyc, n, low;
    bit low_checked;
    job_init();
    go = 1'b1; step(); go = 1'b0;
    chk_b("go_busy", busy, 1'b1);
    chk_b("go_error_clear", error, 1'b0);
    chk_b("go_in_ready", in_ready, 1'b1);
    stream_rows(2*MS, vprob);
    cyc = 0;
    while (!start_mat_mul && cyc < 50) begin step(); cyc++; end
    chk_i("drain_cycles", cyc, WRL + 1);
    chk_b("start_rise", start_mat_mul, 1'b1);
    chk_b("we_c_rise", we_c, 1'b1);
    chk_b("en_wr_off", enable_writing_to_mem, 1'b0);
    chk_i("writes_a", wa_idx, MS);
    chk_i("writes_b", wb_idx, MS);
    if (never_done) begin
      n = 0;
      while (start_mat_mul && n < TMO + 50) begin step(); n++; end
      chk_i("timeout_cycles", n, TMO);
      chk_b("timeout_error", error, 1'b1);
      chk_b("timeout_busy", busy, 1'b0);
      chk_b("timeout_we_c", we_c, 1'b0);
      step(); step();
      chk_b("timeout_no_out", out_seen, 1'b0);
      chk_b("timeout_no_rd", enable_reading_from_mem, 1'b0);
      return;
    end
    for (int i = 0; i < done_lat; i++) begin
      go = go_in_compute && (i == 1);
      step();
    end
    go = 1'b0;
    chk_b("start_held", start_mat_mul, 1'b1);
    done_mat_mul = 1'b1;
    matmul(1'b1);
    step();
    done_mat_mul = 1'b0;
    chk_b("start_drop", start_mat_mul, 1'b0);
    chk_b("we_c_drop", we_c, 1'b0);
    chk_b("busy_after_done", busy, 1'b1);
    in_valid = valid_in_read;
    cyc = 0; low = 0; low_checked = 1'b0;
    while (out_idx < MS && cyc < 400) begin
      if (rmode == 0) out_ready = 1'b1;
      else if (rmode == 1) out_ready = 1'($urandom_range(1));
      else out_ready = !(enable_reading_from_mem && low < 20);
      if (rmode == 2 && !out_ready) low++;
      step();
      cyc++;
      if (rmode == 2 && low == 20 && !low_checked) begin
        chk_i("issued_while_stalled", rd_issued, RDL + 1);
        chk_b("valid_while_stalled", out_valid, 1'b1);
        low_checked = 1'b1;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk_i("rows_out", out_idx, MS);
    chk_b("busy_after_read", busy, 1'b0);
    chk_i("rows_issued", rd_issued, MS);
    step(); step();
    chk_b("out_valid_idle", out_valid, 1'b0);
    chk_i("rows_out_final", out_idx, MS);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MS; i++) begin ram_a[i] = '0; ram_b[i] = '0; ram_c[i] = '0; end
    for (int i = 0; i < 8; i++) addr_hist[i] = '0;
    job_init();
    reset = 1'b1; step(); step();
    chk_reset_outs("por");
    reset = 1'b0; step();

    // identity A, B rows 1..64: C must equal B
    set_identity(); matmul(1'b0); do_job(100, 0, 1'b0, 5, 1'b0, 1'b0);
    // random matrices, bursty input and output
    set_random(); matmul(1'b0); do_job(50, 1, 1'b0, 12, 1'b0, 1'b0);
    // long out_ready stall at the start of readback
    set_random(); matmul(1'b0); do_job(100, 2, 1'b0, 3, 1'b0, 1'b0);
    // multiply never finishes
    set_random(); matmul(1'b0); do_job(100, 0, 1'b1, 0, 1'b0, 1'b0);
    // stray go during compute and in_valid during readback; go also clears error
    set_random(); matmul(1'b0); do_job(70, 1, 1'b0, 6, 1'b1, 1'b1);

    // reset in the middle of LOAD_B with a B write still in flight
    set_random(); matmul(1'b0); job_init();
    go = 1'b1; step(); go = 1'b0;
    stream_rows(MS + 3, 100);
    reset = 1'b1; step();
    chk_reset_outs("mid_load_b");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); chk_b("no_we_b_after_reset", we_b, 1'b0); end
    do_job(100, 1, 1'b0, 4, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
